// File: rtl/sar_search8.sv
// Successive-approximation controller: drives Guess into a registered comparator
// and recovers its A-side operand one bit per trial, stopping early on equality.
module sar_search8 #(
    parameter int CMP_LAT = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [2:0] R,
    output logic [7:0] Guess,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Result,
    output logic       Found,
    output logic [3:0] Trials,
    output logic       Error,
    output logic [1:0] dbg_state
);

    localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(CMP_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [2:0]    idx, idx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    guess_nx, result_nx, res_new;
    logic [3:0]    trials_nx;
    logic          found_nx, error_nx, finished;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            idx    <= 3'd0;
            cnt    <= '0;
            Guess  <= 8'h00;
            Result <= 8'h00;
            Found  <= 1'b0;
            Trials <= 4'd0;
            Error  <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            cnt    <= cnt_nx;
            Guess  <= guess_nx;
            Result <= result_nx;
            Found  <= found_nx;
            Trials <= trials_nx;
            Error  <= error_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;
        guess_nx  = Guess;
        result_nx = Result;
        found_nx  = Found;
        trials_nx = Trials;
        error_nx  = Error;
        res_new   = Result;
        finished  = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    guess_nx  = 8'h80;
                    idx_nx    = 3'd7;
                    cnt_nx    = '0;
                    result_nx = 8'h00;
                    found_nx  = 1'b0;
                    error_nx  = 1'b0;
                    trials_nx = 4'd0;
                    state_nx  = WAIT;
                end
            end
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = EVAL;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            EVAL: begin
                trials_nx = Trials + 4'd1;
                case (R)
                    3'b010: begin
                        res_new  = Guess;
                        found_nx = 1'b1;
                        finished = 1'b1;
                    end
                    3'b100: res_new = Guess;
                    3'b001: res_new = Result;
                    default: begin
                        res_new  = 8'h00;
                        error_nx = 1'b1;
                        finished = 1'b1;
                    end
                endcase
                result_nx = res_new;
                // The last bit has been decided once idx reaches 0, equality or not.
                if (finished || idx == 3'd0) begin
                    guess_nx = 8'h00;
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx - 3'd1;
                    guess_nx = res_new | (8'h01 << (idx - 3'd1));
                    state_nx = WAIT;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign Busy      = (state == WAIT) || (state == EVAL);
    assign Done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_sar_search8.sv
// Bench for sar_search8 with a behavioural registered comparator on the R side.
module tb_sar_search8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] r;
    logic [7:0] guess, result;
    logic       busy, done, found, error;
    logic [3:0] trials;
    logic [1:0] dbg_state;

    logic [7:0] target = 8'h00;
    logic [2:0] r_cmp = 3'b000;
    logic       force_r = 1'b0;
    logic [2:0] force_val = 3'b000;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int last_done_cyc = 0;
    int n_done = 0;
    logic [7:0] cur_t = 8'h00;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    logic guess_on = 1'b0;
    logic b2b_chk = 1'b0;

    // {error, found, trials[3:0], result[7:0]}
    logic [13:0] exp_q[$];

    sar_search8 #(.CMP_LAT(1)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .R(r),
        .Guess(guess), .Busy(busy), .Done(done), .Result(result),
        .Found(found), .Trials(trials), .Error(error), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) r_cmp <= {target > guess, target == guess, target < guess};
    assign r = force_r ? force_val : r_cmp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Trials = 8 - trailing zeros, because the search stops at the target's lowest set bit.
    function automatic logic [13:0] exp_for(input logic [7:0] t);
        int tz;
        tz = 0;
        if (t == 8'h00) return {1'b0, 1'b0, 4'd8, 8'h00};
        while (t[tz] == 1'b0) tz++;
        return {1'b0, 1'b1, 4'(8 - tz), t};
    endfunction

    // scoreboard / monitor
    always @(negedge clk) begin
        logic [13:0] e;
        logic [7:0] m, g_exp;
        int k;
        if (reset) begin
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                n_done++;
                chk("busy_with_done", {31'd0, busy}, 32'd0);
                chk("done_twice", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {24'd0, result}, {24'd0, e[7:0]});
                    chk("trials", {28'd0, trials}, {28'd0, e[11:8]});
                    chk("found", {31'd0, found}, {31'd0, e[12]});
                    chk("error", {31'd0, error}, {31'd0, e[13]});
                    chk("done_cycle", 32'(cyc - accept_cyc + 1), 32'(2 * int'(e[11:8]) + 1));
                end
                last_done_cyc = cyc;
            end
            if (busy && !prev_busy) begin
                accept_cyc = cyc;
                cur_t = target;
                if (b2b_chk) begin
                    chk("idle_gap", 32'(cyc - last_done_cyc), 32'd2);
                    b2b_chk = 1'b0;
                end
            end
            if (busy && guess_on && ((cyc - accept_cyc) % 2 == 1)) begin
                k = (cyc - accept_cyc) / 2;
                m = 8'hFF;
                m = m << (8 - k);
                g_exp = 8'h80;
                g_exp = (cur_t & m) | (g_exp >> k);
                chk("guess_seq", {24'd0, guess}, {24'd0, g_exp});
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_guess"}, {24'd0, guess}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_result"}, {24'd0, result}, 32'd0);
        chk({tag, "_found"}, {31'd0, found}, 32'd0);
        chk({tag, "_trials"}, {28'd0, trials}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || done) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            chk("timeout_idle", 32'd1, 32'd0);
            exp_q.delete();
        end
        tick();
    endtask

    task automatic start_search(input logic [7:0] t);
        target = t;
        start = 1'b1;
        exp_q.push_back(exp_for(t));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rel(input int off);
        int n;
        n = 0;
        while (cyc != accept_cyc + off && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("timeout_rel", 32'd1, 32'd0);
    endtask

    initial begin
        int base;
        int n;
        logic [7:0] t_tab[4];
        t_tab[0] = 8'h80;
        t_tab[1] = 8'h05;
        t_tab[2] = 8'hFF;
        t_tab[3] = 8'h00;

        repeat (3) tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        guess_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_search(t_tab[i]);
            wait_idle();
        end
        for (int i = 0; i < 6; i++) begin
            start_search(8'($urandom_range(0, 255)));
            wait_idle();
        end

        // malformed relation codes abort on the first evaluation
        guess_on = 1'b0;
        force_r = 1'b1;
        force_val = 3'b000;
        exp_q.push_back({1'b1, 1'b0, 4'd1, 8'h00});
        target = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        force_val = 3'b110;
        exp_q.push_back({1'b1, 1'b0, 4'd1, 8'h00});
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        force_r = 1'b0;

        // Start re-pulsed mid-search gives a single Done
        guess_on = 1'b1;
        base = n_done;
        start_search(8'h3C);
        wait_rel(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        chk("single_done", 32'(n_done - base), 32'd1);

        // reset during the fourth trial
        base = n_done;
        start_search(8'h3C);
        wait_rel(6);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check_reset_vals("abort");
        reset = 1'b0;
        repeat (3) tick();
        chk("abort_no_done", 32'(n_done - base), 32'd0);
        start_search(8'h3C);
        wait_idle();

        // Start held high: back-to-back searches
        base = n_done;
        exp_q.push_back(exp_for(8'hA5));
        exp_q.push_back(exp_for(8'hA5));
        target = 8'hA5;
        start = 1'b1;
        n = 0;
        while (n_done == base && n < 40) begin
            tick();
            n++;
        end
        b2b_chk = 1'b1;
        while (!busy && n < 40) begin
            tick();
            n++;
        end
        start = 1'b0;
        if (n >= 40) chk("timeout_b2b", 32'd1, 32'd0);
        wait_idle();
        chk("b2b_dones", 32'(n_done - base), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
